// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the registered one-to-N demultiplexer.
package dmux_pkg;

  // Lane-select width: clog2 of the lane count, never below one bit.
  function automatic int sel_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << w) < n) w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dmux_if.sv
// Payload/select bus into the demux and the flattened lane bus out of it.
interface dmux_if
  import dmux_pkg::*;
#(
  parameter int N_MASTERS  = 4,
  parameter int DATA_WIDTH = 4
);
  localparam int SEL_W = sel_width(N_MASTERS);

  logic [DATA_WIDTH-1:0]           data;
  logic [SEL_W-1:0]                sel;
  logic                            in_valid;
  logic [DATA_WIDTH*N_MASTERS-1:0] op;
  logic [N_MASTERS-1:0]            op_valid;
  logic                            sel_err;

  modport master (
    output data, sel, in_valid,
    input  op, op_valid, sel_err
  );

  modport slave (
    input  data, sel, in_valid,
    output op, op_valid, sel_err
  );
endinterface

// File: rtl/dmux_lane.sv
// One output lane: payload register plus its delivery strobe flop.
module dmux_lane #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  valid
);

  // Load wins over clear; with neither asserted the lane keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= load;
      if (load) begin
        q <= d;
      end else if (clear) begin
        q <= '0;
      end
    end
  end

endmodule

// File: rtl/dmux.sv
// Registered demux: routes a qualified payload to one of N lanes, flags out-of-range selects.
module dmux
  import dmux_pkg::*;
#(
  parameter int N_MASTERS  = 4,
  parameter int DATA_WIDTH = 4,
  parameter int HOLD       = 0
) (
  input logic   clk,
  input logic   rst_n,
  dmux_if.slave bus
);

  localparam int SEL_W = sel_width(N_MASTERS);

  logic                 in_range;
  logic [N_MASTERS-1:0] load;
  logic [N_MASTERS-1:0] clear;
  logic                 sel_err_q;

  wire [DATA_WIDTH*N_MASTERS-1:0] op_flat;
  wire [N_MASTERS-1:0]            valid_flat;

  // Selects past the last lane only exist when N_MASTERS is not a power of two.
  always_comb begin
    in_range = (32'(bus.sel) < 32'(N_MASTERS));
    load     = '0;
    clear    = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      load[i]  = bus.in_valid && in_range && (bus.sel == SEL_W'(i));
      clear[i] = (HOLD == 0) && !load[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= bus.in_valid && !in_range;
    end
  end

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_lane
    dmux_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load[g]),
      .clear(clear[g]),
      .d    (bus.data),
      .q    (op_flat[lane_lo(g, DATA_WIDTH) +: DATA_WIDTH]),
      .valid(valid_flat[g])
    );
  end

  assign bus.op       = op_flat;
  assign bus.op_valid = valid_flat;
  assign bus.sel_err  = sel_err_q;

endmodule

// File: tb/tb_dmux.sv
// Directed bench: three demux configurations driven from one shared stimulus stream.
module tb_dmux;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic [3:0]  sw_data  [4];
  logic [15:0] exp_a    [4];
  logic [15:0] exp_b    [4];
  logic [11:0] exp_c_op [4];
  logic [2:0]  exp_c_vld[4];
  logic        exp_c_err[4];

  logic        r_valid;
  logic [1:0]  r_sel;
  logic [3:0]  r_data;
  logic [15:0] m_op;
  logic [3:0]  m_valid;

  dmux_if #(.N_MASTERS(4), .DATA_WIDTH(4)) bus_a ();
  dmux_if #(.N_MASTERS(4), .DATA_WIDTH(4)) bus_b ();
  dmux_if #(.N_MASTERS(3), .DATA_WIDTH(4)) bus_c ();

  dmux #(.N_MASTERS(4), .DATA_WIDTH(4), .HOLD(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  dmux #(.N_MASTERS(4), .DATA_WIDTH(4), .HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  dmux #(.N_MASTERS(3), .DATA_WIDTH(4), .HOLD(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  always #5 clk = ~clk;

  task automatic apply_stimulus(input logic valid, input logic [1:0] sel, input logic [3:0] data);
    bus_a.in_valid = valid; bus_a.sel = sel; bus_a.data = data;
    bus_b.in_valid = valid; bus_b.sel = sel; bus_b.data = data;
    bus_c.in_valid = valid; bus_c.sel = sel; bus_c.data = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst_n  = 1'b0;
    errors = 0;
    checks = 0;
    sw_data   = '{4'hA, 4'h5, 4'hC, 4'h3};
    exp_a     = '{16'h000A, 16'h0050, 16'h0C00, 16'h3000};
    exp_b     = '{16'h000A, 16'h005A, 16'h0C5A, 16'h3C5A};
    exp_c_op  = '{12'h00A, 12'h05A, 12'hC5A, 12'hC5A};
    exp_c_vld = '{3'b001, 3'b010, 3'b100, 3'b000};
    exp_c_err = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held with live, out-of-range-for-c traffic.
    apply_stimulus(1'b1, 2'd3, 4'hA);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("rst_a_op", 64'(bus_a.op), 64'h0);
      check_output("rst_a_valid", 64'(bus_a.op_valid), 64'h0);
      check_output("rst_b_op", 64'(bus_b.op), 64'h0);
      check_output("rst_c_sel_err", 64'(bus_c.sel_err), 64'h0);
    end
    rst_n = 1'b1;

    $display("[TB] lane sweep");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 2'(i), sw_data[i]);
      step();
      check_output("sweep_a_op", 64'(bus_a.op), 64'(exp_a[i]));
      check_output("sweep_a_valid", 64'(bus_a.op_valid), 64'(4'b0001 << i));
      check_output("sweep_a_sel_err", 64'(bus_a.sel_err), 64'h0);
      check_output("sweep_b_op", 64'(bus_b.op), 64'(exp_b[i]));
      check_output("sweep_b_valid", 64'(bus_b.op_valid), 64'(4'b0001 << i));
      check_output("sweep_c_op", 64'(bus_c.op), 64'(exp_c_op[i]));
      check_output("sweep_c_valid", 64'(bus_c.op_valid), 64'(exp_c_vld[i]));
      check_output("sweep_c_sel_err", 64'(bus_c.sel_err), 64'(exp_c_err[i]));
    end

    apply_stimulus(1'b0, 2'd0, 4'h0);
    step();
    check_output("idle_a_op", 64'(bus_a.op), 64'h0);
    check_output("idle_a_valid", 64'(bus_a.op_valid), 64'h0);
    check_output("idle_b_op", 64'(bus_b.op), 64'h3C5A);
    check_output("idle_b_valid", 64'(bus_b.op_valid), 64'h0);
    check_output("idle_c_op", 64'(bus_c.op), 64'hC5A);
    check_output("idle_c_sel_err", 64'(bus_c.sel_err), 64'h0);

    // Back-to-back writes to the same lane.
    apply_stimulus(1'b1, 2'd1, 4'h7);
    step();
    check_output("b2b1_a_op", 64'(bus_a.op), 64'h0070);
    check_output("b2b1_b_op", 64'(bus_b.op), 64'h3C7A);
    apply_stimulus(1'b1, 2'd1, 4'h9);
    step();
    check_output("b2b2_a_op", 64'(bus_a.op), 64'h0090);
    check_output("b2b2_a_valid", 64'(bus_a.op_valid), 64'b0010);
    check_output("b2b2_b_op", 64'(bus_b.op), 64'h3C9A);

    $display("[TB] async reset mid-stream");
    apply_stimulus(1'b1, 2'd0, 4'hA);
    step();
    check_output("pre_rst_a_op", 64'(bus_a.op), 64'h000A);
    apply_stimulus(1'b1, 2'd1, 4'h5);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_a_op", 64'(bus_a.op), 64'h0);
    check_output("async_a_valid", 64'(bus_a.op_valid), 64'h0);
    check_output("async_b_op", 64'(bus_b.op), 64'h0);
    check_output("async_c_op", 64'(bus_c.op), 64'h0);
    step();
    check_output("in_rst_a_op", 64'(bus_a.op), 64'h0);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 2'd2, 4'hF);
    step();
    check_output("post_rst_a_op", 64'(bus_a.op), 64'h0F00);
    check_output("post_rst_a_valid", 64'(bus_a.op_valid), 64'b0100);
    check_output("post_rst_b_op", 64'(bus_b.op), 64'h0F00);

    $display("[TB] random traffic");
    for (int i = 0; i < 100; i++) begin
      r_valid = 1'($urandom_range(0, 1));
      r_sel   = 2'($urandom_range(0, 3));
      r_data  = 4'($urandom_range(0, 15));
      apply_stimulus(r_valid, r_sel, r_data);
      m_op    = r_valid ? (16'(r_data) << (4 * r_sel)) : 16'h0;
      m_valid = r_valid ? (4'b0001 << r_sel) : 4'b0000;
      step();
      check_output("rnd_a_op", 64'(bus_a.op), 64'(m_op));
      check_output("rnd_a_valid", 64'(bus_a.op_valid), 64'(m_valid));
      check_output("rnd_b_onehot0", 64'($onehot0(bus_b.op_valid)), 64'h1);
      check_output("rnd_c_onehot0", 64'($onehot0(bus_c.op_valid)), 64'h1);
      check_output("rnd_c_sel_err", 64'(bus_c.sel_err), 64'(r_valid && (r_sel == 2'd3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmux.md
DMUX -- requirements
Module: dmux

Interface
REQ-001 N_MASTERS, 4, number of output lanes; legal range 2..64, not required to be a power of two.
REQ-002 DATA_WIDTH, 4, width of each lane in bits; legal range 1..256.
REQ-003 HOLD, 0, lane policy: 0 = unselected lanes driven to zero, 1 = each lane holds its last delivered value.
REQ-004 Derived constant SEL_W = clog2(N_MASTERS); it is not user-overridable.
REQ-005 The block has one clock; reset is asynchronous and active-low. Both are listed below.
REQ-006 clk  input  1  single rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 data  input  DATA_WIDTH  payload to route.
REQ-009 sel  input  SEL_W  destination lane index.
REQ-010 in_valid  input  1  payload qualifier; data and sel are ignored when low.
REQ-011 op  output  DATA_WIDTH*N_MASTERS  flattened lane bus; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 op_valid  output  N_MASTERS  per-lane delivery strobe; bit i corresponds to lane i.
REQ-013 sel_err  output  1  one-cycle pulse flagging an out-of-range sel.

Function
REQ-014 Routing is registered with a fixed latency of 1 cycle: inputs sampled at edge k appear on op/op_valid after edge k.
REQ-015 When in_valid=1 and sel<N_MASTERS at an edge:
- lane sel loads data;
- op_valid becomes one-hot with bit sel set.
REQ-016 When in_valid=0 at an edge:
- op_valid becomes all-zero;
- with HOLD=0, all lanes become zero;
- with HOLD=1, all lanes keep their values.
REQ-017 With HOLD=0, every lane other than sel becomes zero on a valid transfer.
REQ-018 With HOLD=1, every lane other than sel keeps its value on a valid transfer.
REQ-019 When in_valid=1 and sel>=N_MASTERS (possible only for non-power-of-two N_MASTERS):
- no lane is written and op_valid is all-zero;
- the HOLD=0 / HOLD=1 lane rule of REQ-016 applies;
- sel_err is 1 for exactly that cycle.
REQ-020 sel_err is 0 in every other cycle.
REQ-021 op_valid has at most one bit set in any cycle.
REQ-022 Back-to-back transfers to the same or different lanes are accepted every cycle, with no bubble.
REQ-023 There is no combinational path from any input to any output.

Reset
REQ-024 While rst_n=0, all outputs are zero: op all-zero, op_valid all-zero, sel_err=0.
REQ-025 Reset asserts asynchronously (outputs clear without waiting for a clock edge).
REQ-026 rst_n deassertion is synchronous to clk.
REQ-027 A transfer sampled in the same cycle that rst_n falls is discarded.
REQ-028 The first transfer after reset is sampled on the first rising edge with rst_n=1.

Structure
REQ-029 A shared package dmux_pkg holds:
- the clog2-based SEL_W helper function;
- the lane-slice index helper.
REQ-030 One sub-module, dmux_lane, holds one lane's DATA_WIDTH register and its valid flop, with load/clear/hold controls; dmux instantiates N_MASTERS copies via generate.
REQ-031 The top level decodes sel into a one-hot load vector and generates the range check for sel_err.

Verification (N_MASTERS=4, DATA_WIDTH=4, unless stated)
REQ-032 Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> op=16'h0000, op_valid=4'b0000, sel_err=0 throughout.
REQ-033 Lane sweep, HOLD=0: sel=0..3 with data=A,5,C,3 on consecutive cycles, in_valid=1 -> one cycle later op = 16'h000A, 16'h0050, 16'h0C00, 16'h3000; op_valid = 0001, 0010, 0100, 1000.
REQ-034 Hold, HOLD=1: the same sweep, then in_valid=0 -> op=16'h3C5A, op_valid=0000.
REQ-035 Out-of-range: N_MASTERS=3, sel=3, in_valid=1 -> sel_err=1 for one cycle, op_valid=000, lanes unchanged (HOLD=1).
REQ-036 Async reset mid-stream: drop rst_n between edges during the sweep -> outputs go to zero before the next edge; the first post-reset transfer with sel=2, data=F -> op=16'h0F00.
REQ-037 Invariant checker: op_valid is one-hot or zero on every cycle of randomized stimulus.
